// File: rtl/add48_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | add48_pkg - shared width constants and S1 operand type for add48     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package add48_pkg;

  localparam int ADD_W         = 48;
  localparam int CNT_W_DEFAULT = 16;

  typedef struct packed {
    logic [ADD_W:1] a;
    logic [ADD_W:1] b;
    logic           c;
  } s1_t;

  // Subtraction is folded into the operand register as A + ~B + 1.
  function automatic s1_t load_operands(input logic [ADD_W:1] a,
                                        input logic [ADD_W:1] b,
                                        input logic           cin,
                                        input logic           sub);
    s1_t op;
    op.a = a;
    op.b = b ^ {ADD_W{sub}};
    op.c = sub | cin;
    return op;
  endfunction

  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder48.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder48 - combinational 48-bit adder with carry-in and carry-out     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module adder48
  import add48_pkg::*;
(
  input  logic [ADD_W:1] A,
  input  logic [ADD_W:1] B,
  input  logic           c0,
  output logic [ADD_W:1] S,
  output logic           c48
);

  logic [ADD_W:0] total;

  assign total = {1'b0, A} + {1'b0, B} + {{ADD_W{1'b0}}, c0};
  assign S     = total[ADD_W-1:0];
  assign c48   = total[ADD_W];

endmodule
`default_nettype wire

// File: rtl/add48_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | add48_stage - two-stage valid/ready 48-bit add/sub with op counter;  |
// | ADD48_OVF_EN adds the signed-overflow output out_ovf.   Rev 1.0      |
// +----------------------------------------------------------------------+
module add48_stage
  import add48_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [48:1]      in_a,
  input  logic [48:1]      in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [48:1]      out_s,
  output logic             out_cout,
  output logic [CNT_W-1:0] out_cnt
`ifdef ADD48_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  s1_t            s1_q;
  logic           s1_valid;
  logic           in_fire;
  logic           advance;
  logic           out_fire;
  logic [ADD_W:1] sum;
  logic           carry;

  assign out_fire = out_valid && out_ready;
  assign advance  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;

  // Operand stage: a new beat may land in the same cycle S1 empties into S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_q     <= load_operands(in_a, in_b, in_cin, in_sub);
      end else if (advance) begin
        s1_valid <= 1'b0;
      end
    end
  end

  adder48 u_adder48 (
    .A   (s1_q.a),
    .B   (s1_q.b),
    .c0  (s1_q.c),
    .S   (sum),
    .c48 (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_s     <= '0;
      out_cout  <= 1'b0;
    end else begin
      if (advance) begin
        out_valid <= 1'b1;
        out_s     <= sum;
        out_cout  <= carry;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else if (out_fire) begin
      out_cnt <= out_cnt + CNT_ONE;
    end
  end

`ifdef ADD48_OVF_EN
  // Uses the post-inversion B so the same test covers add and subtract.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ovf <= 1'b0;
    end else if (advance) begin
      out_ovf <= signed_ovf(s1_q.a[ADD_W], s1_q.b[ADD_W], sum[ADD_W]);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_add48_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_add48_stage - scoreboard bench for add48_stage (CNT_W = 4)        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_add48_stage;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [48:1]      in_a = '0;
  logic [48:1]      in_b = '0;
  logic             in_cin = 1'b0;
  logic             in_sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [48:1]      out_s;
  logic             out_cout;
  logic [CNT_W-1:0] out_cnt;
`ifdef ADD48_OVF_EN
  logic             out_ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [48:1] s;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  add48_stage #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_cout  (out_cout),
    .out_cnt   (out_cnt)
`ifdef ADD48_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [48:1] a, input logic [48:1] b,
                                 input logic cin, input logic sub);
    exp_t        e;
    logic [48:1] bb;
    logic [49:1] r;
    bb     = sub ? ~b : b;
    r      = {1'b0, a} + {1'b0, bb} + {48'd0, (sub ? 1'b1 : cin)};
    e.s    = r[48:1];
    e.cout = r[49];
    e.ovf  = (a[48] == bb[48]) && (r[48] != a[48]);
    return e;
  endfunction

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected: got s=%h with no beat outstanding", out_s);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (out_s !== e.s || out_cout !== e.cout
`ifdef ADD48_OVF_EN
              || out_ovf !== e.ovf
`endif
             )
            $display("FAIL sb_result: got s=%h cout=%b want s=%h cout=%b ovf=%b",
                     out_s, out_cout, e.s, e.cout, e.ovf);
          else
            n_pass++;
        end
      end
      if (in_valid && in_ready)
        sb.push_back(model(in_a, in_b, in_cin, in_sub));
    end
  end

  task automatic idle_inputs;
    in_valid = 1'b0;
    in_a     = 'x;
    in_b     = 'x;
    in_cin   = 1'bx;
    in_sub   = 1'bx;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    idle_inputs();
    sb.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic send_beat(input logic [48:1] a, input logic [48:1] b,
                           input logic cin, input logic sub);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        idle_inputs();
        return;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    $display("FAIL send_timeout: in_ready stayed %b want 1", in_ready);
    idle_inputs();
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_s !== 48'h0) $display("FAIL rst_out_s: got %h want 0", out_s); else n_pass++;
    n_checks++; if (out_cout !== 1'b0) $display("FAIL rst_cout: got %b want 0", out_cout); else n_pass++;
    n_checks++; if (out_cnt !== 4'd0) $display("FAIL rst_cnt: got %0d want 0", out_cnt); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready: got %b want 1", in_ready); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 48'h0000_0000_0001; in_b = 48'h0000_0000_0002;
    in_cin = 1'b1; in_sub = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL add_in_ready: got %b want 1", in_ready); else n_pass++;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL add_lat1_valid: got %b want 0", out_valid); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL add_lat2_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_s !== 48'h0000_0000_0004) $display("FAIL add_s: got %h want 000000000004", out_s); else n_pass++;
    n_checks++; if (out_cout !== 1'b0) $display("FAIL add_cout: got %b want 0", out_cout); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (out_cnt !== 4'd1) $display("FAIL add_cnt: got %0d want 1", out_cnt); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL add_drained: got %b want 0", out_valid); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap;
    bit ok;
    out_ready = 1'b1;
    send_beat(48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 1'b0, 1'b0);
    wait_out(ok);
    n_checks++; if (!ok) $display("FAIL wrap_timeout: got out_valid=0 want 1"); else n_pass++;
    n_checks++; if (out_s !== 48'h0) $display("FAIL wrap_s: got %h want 000000000000", out_s); else n_pass++;
    n_checks++; if (out_cout !== 1'b1) $display("FAIL wrap_cout: got %b want 1", out_cout); else n_pass++;
`ifdef ADD48_OVF_EN
    n_checks++; if (out_ovf !== 1'b0) $display("FAIL wrap_ovf: got %b want 0", out_ovf); else n_pass++;
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_sub_ovf;
    bit ok;
    out_ready = 1'b1;
    send_beat(48'h7FFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b1);
    wait_out(ok);
    n_checks++; if (!ok) $display("FAIL sub_timeout: got out_valid=0 want 1"); else n_pass++;
    n_checks++; if (out_s !== 48'h8000_0000_0000) $display("FAIL sub_s: got %h want 800000000000", out_s); else n_pass++;
    n_checks++; if (out_cout !== 1'b0) $display("FAIL sub_cout: got %b want 0", out_cout); else n_pass++;
`ifdef ADD48_OVF_EN
    n_checks++; if (out_ovf !== 1'b1) $display("FAIL sub_ovf: got %b want 1", out_ovf); else n_pass++;
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    logic [48:1] ea [4];
    logic [48:1] eb [4];
    exp_t        first;
    int          idx;
    bit          acc;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      ea[i] = 48'({$urandom(), $urandom()});
      eb[i] = 48'({$urandom(), $urandom()});
    end
    first = model(ea[0], eb[0], 1'b0, 1'b0);
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      if (idx == 4 && sb.size() == 0) break;
      out_ready = (c >= 5);
      if (idx < 4) begin
        in_valid = 1'b1; in_a = ea[idx]; in_b = eb[idx]; in_cin = 1'b0; in_sub = 1'b0;
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      if (c >= 2 && c < 5) begin
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready c%0d: got %b want 0", c, in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid c%0d: got %b want 1", c, out_valid); else n_pass++;
        n_checks++; if (out_s !== first.s) $display("FAIL bp_hold c%0d: got %h want %h", c, out_s, first.s); else n_pass++;
      end
      if (c == 4) begin
        n_checks++; if (idx != 2) $display("FAIL bp_accepted: got %0d want 2", idx); else n_pass++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
    end
    idle_inputs();
    @(negedge clk);
    n_checks++; if (idx != 4 || sb.size() != 0) $display("FAIL bp_drain: got accepted=%0d left=%0d want 4/0", idx, sb.size()); else n_pass++;
    n_checks++; if (out_cnt !== 4'd4) $display("FAIL bp_cnt: got %0d want 4", out_cnt); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int  idx;
    bit  acc;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10 && idx < 2; c++) begin
      in_valid = 1'b1; in_a = 48'h1234_5678_9ABC + 48'(c); in_b = 48'h1; in_cin = 1'b0; in_sub = 1'b0;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    idle_inputs();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL mid_full: got valid=%b ready=%b want 1/0", out_valid, in_ready); else n_pass++;
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_cnt !== 4'd0) $display("FAIL mid_cnt: got %0d want 0", out_cnt); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b want 1", in_ready); else n_pass++;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_stale c%0d: got %b want 0", c, out_valid); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    int sent;
    bit acc;
    apply_reset();
    sent = 0;
    for (int c = 0; c < 300; c++) begin
      if (sent == 30 && sb.size() == 0) break;
      out_ready = ($urandom_range(0, 9) < 7) || (sent == 30);
      if (sent < 30 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_a     = 48'({$urandom(), $urandom()});
        in_b     = 48'({$urandom(), $urandom()});
        in_cin   = 1'($urandom_range(0, 1));
        in_sub   = 1'($urandom_range(0, 1));
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
    end
    idle_inputs();
    @(negedge clk);
    n_checks++; if (sent != 30 || sb.size() != 0) $display("FAIL b2b_drain: got sent=%0d left=%0d want 30/0", sent, sb.size()); else n_pass++;
    n_checks++; if (out_cnt !== 4'd14) $display("FAIL b2b_cnt: got %0d want 14", out_cnt); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_cnt_wrap;
    int  sent;
    bit  acc;
    apply_reset();
    out_ready = 1'b1;
    sent = 0;
    for (int c = 0; c < 100; c++) begin
      if (sent == 17 && sb.size() == 0) break;
      if (sent < 17) begin
        in_valid = 1'b1; in_a = 48'(c); in_b = 48'hFFFF_0000_0000; in_cin = 1'b1; in_sub = 1'b0;
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
    end
    idle_inputs();
    @(negedge clk);
    n_checks++; if (sent != 17 || sb.size() != 0) $display("FAIL cw_drain: got sent=%0d left=%0d want 17/0", sent, sb.size()); else n_pass++;
    n_checks++; if (out_cnt !== 4'd1) $display("FAIL cw_cnt: got %0d want 1", out_cnt); else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_wrap();
    test_sub_ovf();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_cnt_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/add48_stage.md
ADD48_STAGE -- requirements
Module: add48_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of completed-operation counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  operand beat offered.
REQ-005 SHALL have port in_ready  output  1  block accepts operand beat.
REQ-006 SHALL have port in_a  input  [48:1]  operand A.
REQ-007 SHALL have port in_b  input  [48:1]  operand B.
REQ-008 SHALL have port in_cin  input  1  carry-in (add mode only).
REQ-009 SHALL have port in_sub  input  1  1 = compute A-B, 0 = A+B+cin.
REQ-010 SHALL have port out_valid  output  1  result beat held.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port out_s  output  [48:1]  48-bit sum/difference.
REQ-013 SHALL have port out_cout  output  1  carry-out of bit 48.
REQ-014 SHALL have port out_cnt  output  [CNT_W-1:0]  completed output handshakes.

Function
REQ-015 SHALL transfer input on in_valid&&in_ready and output on out_valid&&out_ready rising edges.
REQ-016 SHALL be two register stages: S1 = operand register, S2 = result register; latency in-accept to out_valid = 2 cycles when unstalled.
REQ-017 SHALL load S1 with a=in_a, b=in_b XOR {48{in_sub}}, c=in_sub ? 1 : in_cin.
REQ-018 SHALL compute S2 data combinationally from S1 as a+b+c, full 48-bit, carry into out_cout, no saturation, sum wraps mod 2^48.
REQ-019 SHALL advance S1->S2 when s1_valid && (!out_valid || out_ready).
REQ-020 SHALL drive in_ready = !s1_valid || !out_valid || out_ready (combinational, full throughput 1 beat/cycle).
REQ-021 SHALL hold out_s, out_cout, out_valid stable while out_valid && !out_ready.
REQ-022 SHALL clear out_valid on output handshake with no S1 advance same cycle; simultaneous accept/advance/drain SHALL lose no beat.
REQ-023 SHALL increment out_cnt by 1 per output handshake, wrapping all-ones -> 0.
REQ-024 SHALL ignore in_a/in_b/in_cin/in_sub when in_valid=0; no X propagation into valid flags.

Reset
REQ-025 SHALL on rst_n=0 asynchronously clear s1_valid, out_valid, out_s, out_cout, out_cnt (and out_ovf) to 0.
REQ-026 SHALL drop in-flight beats on reset mid-operation; in_ready SHALL read 1 during and after reset.
REQ-027 SHALL release reset synchronously-safe: first accept possible on first clk edge with rst_n=1.

Configuration
REQ-028 SHALL, with ADD48_OVF_EN defined, add port out_ovf output 1 = signed two's-complement overflow: (a[48]==b[48]) && (sum[48]!=a[48]), using S1 post-inversion operands, registered with S2.
REQ-029 SHALL, without ADD48_OVF_EN, omit out_ovf port and its logic entirely.

Structure
REQ-030 SHALL place constant ADD_W=48 and default counter width in shared package add48_pkg.
REQ-031 SHALL instantiate existing adder48 (A,B,c0 -> S,c48) once as the S1->S2 combinational datapath; no other sub-modules.

Verification
REQ-032 SHALL test add: A=0x0000_0000_0001, B=0x0000_0000_0002, cin=1, sub=0 -> 2 cycles later out_s=0x000000000004, cout=0, out_cnt=1.
REQ-033 SHALL test wrap: A=0xFFFF_FFFF_FFFF, B=0x000000000001, cin=0 -> out_s=0, cout=1; with ADD48_OVF_EN ovf=0.
REQ-034 SHALL test sub/overflow: A=0x7FFF_FFFF_FFFF, B=0xFFFF_FFFF_FFFF, sub=1 -> out_s=0x800000000000, cout=0, ovf=1.
REQ-035 SHALL test backpressure: 4 back-to-back beats, out_ready=0 for 5 cycles -> in_ready falls after 2 accepted, out_s held, then 4 results in order, out_cnt=4.
REQ-036 SHALL test reset mid-stream: rst_n low with both stages valid -> out_valid=0, out_cnt=0 immediately, no stale result after release.
REQ-037 SHALL test counter wrap with CNT_W=4: 17 handshakes -> out_cnt=1.
